inequality_sweep_ctrl: RTL and testbench
========================================

# inequality_sweep_ctrl

Sequencer that exhaustively drives the 4-bit input of a combinational standard-form comparator (the `Inequality` datapath) through every code, samples its outputs after a programmable settle time, and assembles a per-output minterm truth table. Optionally compares each sampled output bit against an expected minterm mask and records the first mismatch. Sits between a bench or self-test host and one comparator instance as its only input driver.

## Interface
- `N_IN`, 4, comparator input width; sweep covers 2^N_IN codes
- `N_OUT`, 3, comparator output width
- `SETTLE`, 1, idle cycles between driving `num` and sampling `f_in`; legal range 0..15

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `num`  out  N_IN  code driven to the comparator input
- `f_in`  in  N_OUT  comparator output
- `exp_mask`  in  N_OUT*2^N_IN  expected minterms; bit b*2^N_IN+v = expected f_in[b] at num=v; must be stable while `busy`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `tt`  out  N_OUT*2^N_IN  captured truth table, same bit layout as `exp_mask`
- `mismatch`  out  1  sticky: at least one sampled bit differed from `exp_mask`
- `fail_num`  out  N_IN  code of first mismatching vector
- `fail_bit`  out  clog2(N_OUT)  lowest mismatching bit index within that vector

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE: `start`=1 → clear `tt`, `mismatch`, `fail_num`, `fail_bit`; `num`=0; go to DRIVE.
- DRIVE: settle counter counts SETTLE cycles; at terminal count, or immediately if SETTLE=0, go to SAMPLE.
- SAMPLE: write `f_in` into `tt` at column `num`. If any bit ≠ `exp_mask` and `mismatch`=0: set `mismatch`, load `fail_num`=`num` and `fail_bit`=lowest differing index. Later mismatches leave `fail_*` unchanged. If `num`=2^N_IN−1, go to FINISH; else increment `num` and return to DRIVE.
- The vector counter is N_IN+1 bits internally so termination needs no wrap test. `num` never wraps during a sweep.
- FINISH: `done`=1 for one cycle, `num` returns to 0, go to IDLE.
- `start` outside IDLE is ignored. `start` held high relaunches one cycle after FINISH.
- `tt`, `mismatch`, `fail_*` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: `num`=0, `busy`=0, `done`=0, `tt`=0, `mismatch`=0, `fail_num`=0, `fail_bit`=0, state IDLE.
- `busy`=1 from the cycle after `start` is accepted through the FINISH cycle.
- Per vector: SETTLE+1 cycles (SETTLE in DRIVE, 1 in SAMPLE). `num` changes only on the SAMPLE→DRIVE edge.
- `done` asserts exactly 2^N_IN·(SETTLE+1)+1 cycles after the `start` edge. Default parameters: 33.
- `rst_n`=0 mid-sweep: at the next edge, all outputs return to reset values and any partial `tt` is discarded.
- `f_in` is sampled only in SAMPLE. Glitches during DRIVE have no effect.

## Structure
- Shared package `stdform_pkg`: state enum (IDLE, DRIVE, SAMPLE, FINISH), default widths, and the `TT_W = N_OUT<<N_IN` helper constant.
- One sub-module, `settle_counter`: loadable down-counter with a terminal-count flag, reusable by other standard-form sweepers.
- The comparator is instantiated outside this block, never inside it.

## Test plan
- Reset, then idle 5 cycles. Required: all outputs at reset values; `busy`=0.
- Default parameters, comparator model OUT={num>5, num>7, num[0]}, `exp_mask`={16'hFFC0, 16'hFF00, 16'hAAAA}, `start` pulse. Required: `done` at cycle 33; `tt`=`exp_mask`; `mismatch`=0; at num=9, sampled f_in=3'b111.
- Same model with `exp_mask` bit for OUT[1] at num=9 cleared. Required: `mismatch`=1, `fail_num`=9, `fail_bit`=1. Also clear the OUT[0] bit at num=11. Required: `fail_num` still 9.
- SETTLE=0 and SETTLE=3 builds. Required: `done` at cycle 17 and cycle 65 respectively; `tt` identical to the default build.
- `rst_n` low for one cycle at cycle 12 of a sweep. Required: next cycle `busy`=0, `tt`=0, `num`=0. A later `start` completes normally.
- `start` pulsed at cycle 10 of a sweep, then held high through FINISH. Required: the mid-sweep pulse is ignored; a second sweep begins the cycle after `done`.

Source files
------------

// File: rtl/stdform_pkg.sv
// Shared types and constants for the standard-form sweep sequencers:
// sweep FSM states, default widths and truth-table sizing helpers.
package stdform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_N_OUT  = 3;
  localparam int DEF_SETTLE = 1;
  localparam int SETTLE_W   = 4;
  localparam int TT_W       = DEF_N_OUT << DEF_N_IN;

  function automatic int tt_width(input int n_out, input int n_in);
    return n_out << n_in;
  endfunction

  // Index width that stays legal for a single-output comparator.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scans from the top down so the lowest set bit is the one that sticks.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[4:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a registered terminal-count flag, used to hold
// a sweeper in its drive state while the datapath under test settles.
module settle_counter
  import stdform_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  // Next count: load wins, otherwise decrement and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    tc_d = (cnt_d == {W{1'b0}});
  end

  // Count and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc = tc_q;

endmodule

// File: rtl/inequality_sweep_ctrl.sv
// Walks a combinational comparator through every input code, samples its
// outputs after a settle delay, builds the truth table and flags mismatches.
module inequality_sweep_ctrl
  import stdform_pkg::*;
#(
  parameter  int N_IN   = DEF_N_IN,
  parameter  int N_OUT  = DEF_N_OUT,
  parameter  int SETTLE = DEF_SETTLE,
  localparam int TW     = N_OUT << N_IN,
  localparam int FB_W   = idx_width(N_OUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] num,
  input  logic [N_OUT-1:0] f_in,
  input  logic [TW-1:0]   exp_mask,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   tt,
  output logic            mismatch,
  output logic [N_IN-1:0] fail_num,
  output logic [FB_W-1:0] fail_bit
);

  localparam int VEC_W = N_IN + 1;
  localparam int N_VEC = 1 << N_IN;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : {SETTLE_W{1'b0}};
  // With no settle time the drive state is skipped entirely.
  localparam sweep_state_e ENTRY_ST = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;

  sweep_state_e    state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d, vec_inc_s;
  logic [TW-1:0]   tt_q, tt_d;
  logic            mismatch_q, mismatch_d;
  logic [N_IN-1:0] fail_num_q, fail_num_d;
  logic [FB_W-1:0] fail_bit_q, fail_bit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cnt_load_s, cnt_en_s, cnt_tc_s;
  logic [N_OUT-1:0] exp_col_s, diff_s;
  logic [N_IN-1:0] col_s;

  settle_counter #(
    .W (SETTLE_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (SETTLE_LOAD),
    .en       (cnt_en_s),
    .tc       (cnt_tc_s)
  );

  assign col_s = vec_q[N_IN-1:0];

  // Expected column for the current code and its difference from the sample.
  always_comb begin
    exp_col_s = {N_OUT{1'b0}};
    for (int b = 0; b < N_OUT; b++) begin
      exp_col_s[b] = exp_mask[b*N_VEC + int'(col_s)];
    end
    diff_s = f_in ^ exp_col_s;
  end

  // Sweep FSM next-state, truth-table capture and first-mismatch recording.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    tt_d       = tt_q;
    mismatch_d = mismatch_q;
    fail_num_d = fail_num_q;
    fail_bit_d = fail_bit_q;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    vec_inc_s  = vec_q + {{(VEC_W-1){1'b0}}, 1'b1};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tt_d       = {TW{1'b0}};
          mismatch_d = 1'b0;
          fail_num_d = {N_IN{1'b0}};
          fail_bit_d = {FB_W{1'b0}};
          vec_d      = {VEC_W{1'b0}};
          cnt_load_s = 1'b1;
          state_d    = ENTRY_ST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        cnt_en_s = 1'b1;
        if (cnt_tc_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_SAMPLE: begin
        for (int b = 0; b < N_OUT; b++) begin
          tt_d[b*N_VEC + int'(col_s)] = f_in[b];
        end
        if ((diff_s != {N_OUT{1'b0}}) && !mismatch_q) begin
          mismatch_d = 1'b1;
          fail_num_d = col_s;
          fail_bit_d = FB_W'(lowest_set(32'(diff_s)));
        end else begin
          mismatch_d = mismatch_q;
        end
        // The extra counter bit marks the end without testing for a wrap.
        if (vec_inc_s[N_IN]) begin
          state_d = ST_FINISH;
        end else begin
          vec_d      = vec_inc_s;
          cnt_load_s = 1'b1;
          state_d    = ENTRY_ST;
        end
      end
      ST_FINISH: begin
        vec_d   = {VEC_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        vec_d   = {VEC_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= {VEC_W{1'b0}};
      tt_q       <= {TW{1'b0}};
      mismatch_q <= 1'b0;
      fail_num_q <= {N_IN{1'b0}};
      fail_bit_q <= {FB_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      tt_q       <= tt_d;
      mismatch_q <= mismatch_d;
      fail_num_q <= fail_num_d;
      fail_bit_q <= fail_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign num      = col_s;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt       = tt_q;
  assign mismatch = mismatch_q;
  assign fail_num = fail_num_q;
  assign fail_bit = fail_bit_q;

endmodule

// File: tb/tb_inequality_sweep_ctrl.sv
// Scoreboard bench: three sweepers (SETTLE 0, 1, 3) each drive their own
// comparator model; a monitor pops expected results whenever done pulses.
module tb_inequality_sweep_ctrl;

  localparam logic [47:0] GOLD = {16'hFFC0, 16'hFF00, 16'hAAAA};

  typedef struct {
    int          lat;
    logic [47:0] tt;
    logic        mm;
    logic [3:0]  fn;
    logic [1:0]  fb;
  } exp_t;

  // Cycles from the accepting start edge to the edge that captures done.
  int LAT [3] = '{17, 33, 65};

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_a;
  logic [47:0] exp_mask;
  logic [3:0]  num_a  [3];
  logic [2:0]  f_a    [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic [47:0] tt_a   [3];
  logic        mm_a   [3];
  logic [3:0]  fn_a   [3];
  logic [1:0]  fb_a   [3];
  logic [3:0]  num_prev1;

  exp_t sb_q [3][$];
  int   cyc  [3];
  int   gcyc;
  int   checks;
  int   failures;

  function automatic logic [2:0] cmp_model(input logic [3:0] n);
    return {(n > 4'd5), (n > 4'd7), n[0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    inequality_sweep_ctrl #(
      .N_IN   (4),
      .N_OUT  (3),
      .SETTLE (S)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_a[g]),
      .num      (num_a[g]),
      .f_in     (f_a[g]),
      .exp_mask (exp_mask),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .tt       (tt_a[g]),
      .mismatch (mm_a[g]),
      .fail_num (fn_a[g]),
      .fail_bit (fb_a[g])
    );
    // The SETTLE=1 comparator output is garbage in the cycle after num moves.
    if (g == 1) begin : g_glitch
      assign f_a[g] = cmp_model(num_a[g]) ^
                      ((busy_a[g] && (num_a[g] != num_prev1)) ? 3'b111 : 3'b000);
    end else begin : g_clean
      assign f_a[g] = cmp_model(num_a[g]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    num_prev1 <= num_a[1];
    gcyc <= gcyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && start_a[i] && !busy_a[i]) cyc[i] <= 0;
      else cyc[i] <= cyc[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever any instance pulses done.
  exp_t e_m;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_a[i] === 1'b1) begin
        if (sb_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done inst=%0d", i);
        end else begin
          e_m = sb_q[i].pop_front();
          chk($sformatf("latency[%0d]", i), 64'(cyc[i] + 1), 64'(e_m.lat));
          chk($sformatf("tt[%0d]", i), 64'(tt_a[i]), 64'(e_m.tt));
          chk($sformatf("mismatch[%0d]", i), 64'(mm_a[i]), 64'(e_m.mm));
          chk($sformatf("fail_num[%0d]", i), 64'(fn_a[i]), 64'(e_m.fn));
          chk($sformatf("fail_bit[%0d]", i), 64'(fb_a[i]), 64'(e_m.fb));
          chk($sformatf("busy_at_done[%0d]", i), 64'(busy_a[i]), 64'd1);
        end
      end
    end
  end

  task automatic push(input int i, input logic mm, input logic [3:0] fn, input logic [1:0] fb);
    exp_t e;
    e.lat = LAT[i];
    e.tt  = GOLD;
    e.mm  = mm;
    e.fn  = fn;
    e.fb  = fb;
    sb_q[i].push_back(e);
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (k >= lim) chk("drain_timeout", 64'(k), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  task automatic run_all(input logic [47:0] mask, input logic mm, input logic [3:0] fn,
                         input logic [1:0] fb);
    exp_mask = mask;
    for (int i = 0; i < 3; i++) push(i, mm, fn, fb);
    @(posedge clk);
    #1 start_a = 3'b111;
    @(posedge clk);
    #1 start_a = 3'b000;
    drain(300);
  endtask

  task automatic wait_done1(input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done_a[1] === 1'b1) begin
        at = gcyc;
        break;
      end
    end
    if (at < 0) chk("wait_done_timeout", 64'(lim), 64'(0));
  endtask

  initial begin
    int g1;
    int g2;
    checks = 0;
    failures = 0;
    gcyc = 0;
    rst_n = 1'b0;
    start_a = 3'b000;
    exp_mask = GOLD;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_num", 64'(num_a[i]), 64'd0);
      chk("rst_busy", 64'(busy_a[i]), 64'd0);
      chk("rst_done", 64'(done_a[i]), 64'd0);
      chk("rst_tt", 64'(tt_a[i]), 64'd0);
      chk("rst_mismatch", 64'(mm_a[i]), 64'd0);
      chk("rst_fail_num", 64'(fn_a[i]), 64'd0);
      chk("rst_fail_bit", 64'(fb_a[i]), 64'd0);
    end

    run_all(GOLD, 1'b0, 4'd0, 2'd0);
    chk("col9", 64'({tt_a[1][41], tt_a[1][25], tt_a[1][9]}), 64'(3'b111));
    run_all(GOLD & ~(48'd1 << 25), 1'b1, 4'd9, 2'd1);
    run_all(GOLD & ~(48'd1 << 25) & ~(48'd1 << 11), 1'b1, 4'd9, 2'd1);
    run_all((GOLD & ~(48'd1 << 44)) | (48'd1 << 12), 1'b1, 4'd12, 2'd0);
    run_all(GOLD ^ (48'd1 << 47), 1'b1, 4'd15, 2'd2);
    run_all(GOLD ^ 48'd1, 1'b1, 4'd0, 2'd0);

    // Abort a sweep with a one-cycle reset at cycle 12.
    exp_mask = GOLD & ~(48'd1 << 3);
    @(posedge clk);
    #1 start_a[1] = 1'b1;
    @(posedge clk);
    #1 start_a[1] = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_mismatch", 64'(mm_a[1]), 64'd1);
    chk("pre_rst_fail_num", 64'(fn_a[1]), 64'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy_a[1]), 64'd0);
    chk("abort_tt", 64'(tt_a[1]), 64'd0);
    chk("abort_num", 64'(num_a[1]), 64'd0);
    chk("abort_mismatch", 64'(mm_a[1]), 64'd0);
    chk("abort_fail_num", 64'(fn_a[1]), 64'd0);
    repeat (3) @(posedge clk);
    run_all(GOLD, 1'b0, 4'd0, 2'd0);

    // Mid-sweep start is ignored; start held through FINISH relaunches.
    exp_mask = GOLD;
    push(1, 1'b0, 4'd0, 2'd0);
    push(1, 1'b0, 4'd0, 2'd0);
    @(posedge clk);
    #1 start_a[1] = 1'b1;
    @(posedge clk);
    #1 start_a[1] = 1'b0;
    repeat (9) @(posedge clk);
    #1 start_a[1] = 1'b1;
    wait_done1(100, g1);
    @(posedge clk);
    @(negedge clk);
    chk("relaunch_idle_busy", 64'(busy_a[1]), 64'd0);
    @(posedge clk);
    #1 start_a[1] = 1'b0;
    @(negedge clk);
    chk("relaunch_busy", 64'(busy_a[1]), 64'd1);
    wait_done1(100, g2);
    chk("relaunch_spacing", 64'(g2 - g1), 64'd34);
    drain(100);

    for (int i = 0; i < 3; i++) chk("sb_empty", 64'(sb_q[i].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
